// File: rtl/shift_tx_sequencer_pkg.sv
`default_nettype none
// ============================================================================
// Module   : shift_pkg
// Brief    : Shared types and helpers for the shift-register controller family.
// Revision : 1.0 - initial release
// ============================================================================
package shift_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    // A zero or oversized request means "send the whole register".
    function automatic int unsigned clamp_len(input int unsigned len,
                                              input int unsigned width);
        return ((len == 0) || (len > width)) ? width : len;
    endfunction

endpackage
`default_nettype wire

// File: rtl/shift_tx_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module   : shift_tx_sequencer_if
// Brief    : Load handshake, stall and serial-output bundle of the sequencer.
// Revision : 1.0 - initial release
// ============================================================================
interface shift_tx_sequencer_if #(
    parameter int WIDTH = 8,
    parameter int CNT_W = $clog2(WIDTH + 1)
) ();
    logic             load_valid;
    logic             load_ready;
    logic [WIDTH-1:0] load_data;
    logic [CNT_W-1:0] load_len;
    logic             hold;
    logic             dout;
    logic             dout_valid;
    logic             busy;
    logic             done;

    modport master (
        output load_valid, load_data, load_len, hold,
        input  load_ready, dout, dout_valid, busy, done
    );

    modport slave (
        input  load_valid, load_data, load_len, hold,
        output load_ready, dout, dout_valid, busy, done
    );
endinterface
`default_nettype wire

// File: rtl/shift_right_piso.sv
`default_nettype none
// ============================================================================
// Module   : shift_right_piso
// Brief    : Parallel-load, shift-right register with zero fill; sout = q[0].
// Revision : 1.0 - initial release
// ============================================================================
module shift_right_piso #(
    parameter int WIDTH = 8
) (
    input  wire logic             clk,
    input  wire logic             reset,
    input  wire logic             load,
    input  wire logic             shift_en,
    input  wire logic [WIDTH-1:0] pdata,
    output logic                  sout
);
    logic [WIDTH-1:0] r_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_q <= '0;
        end else if (load) begin
            r_q <= pdata;
        end else if (shift_en) begin
            r_q <= {1'b0, r_q[WIDTH-1:1]};
        end
    end

    assign sout = r_q[0];
endmodule
`default_nettype wire

// File: rtl/shift_tx_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : shift_tx_sequencer
// Brief    : Accepts a parallel word and shifts it out LSB-first for a
//            programmable number of bits, with stall and completion pulse.
// Revision : 1.0 - initial release
// ============================================================================
module shift_tx_sequencer
    import shift_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  wire logic              clk,
    input  wire logic              reset,
    shift_tx_sequencer_if.slave    bus
);
    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_len_eff;
    logic             w_load;
    logic             w_shift;
    logic             w_sout;

    assign w_len_eff = CNT_W'(clamp_len(32'(bus.load_len), 32'(WIDTH)));
    assign w_load    = (r_state == IDLE) && bus.load_valid;
    assign w_shift   = (r_state == SHIFT) && !bus.hold;

    shift_right_piso #(
        .WIDTH (WIDTH)
    ) u_piso (
        .clk      (clk),
        .reset    (reset),
        .load     (w_load),
        .shift_en (w_shift),
        .pdata    (bus.load_data),
        .sout     (w_sout)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
            r_cnt   <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (bus.load_valid) begin
                        r_cnt   <= w_len_eff;
                        r_state <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (!bus.hold) begin
                        r_cnt <= r_cnt - CNT_W'(1);
                        if (r_cnt == CNT_W'(1)) begin
                            r_state <= DONE;
                        end
                    end
                end
                DONE:    r_state <= IDLE;
                default: r_state <= IDLE;
            endcase
        end
    end

    // The register may still hold unsent upper bits after a short frame,
    // so dout is gated to SHIFT rather than taken straight from the register.
    assign bus.dout       = (r_state == SHIFT) && w_sout;
    assign bus.dout_valid = (r_state == SHIFT) && !bus.hold;
    assign bus.busy       = (r_state != IDLE);
    assign bus.load_ready = (r_state == IDLE);
    assign bus.done       = (r_state == DONE);
endmodule
`default_nettype wire
